// File: rtl/scan_seq_pkg.sv
// scan_seq_pkg: shared states, channel constants and next-channel lookup for the scan sequencer
package scan_seq_pkg;
  localparam int NUM_CH = 8;
  localparam int CH_W = 3;
  typedef enum logic [1:0] {IDLE, DWELL, GAP} state_t;
  typedef struct packed {
    logic [CH_W-1:0] nxt;
    logic last;
  } ch_step_t;
  function automatic ch_step_t next_ch(input logic [CH_W-1:0] cur, input logic [NUM_CH-1:0] mask);
    ch_step_t r;
    r.nxt = '0;
    r.last = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (!mask[i]) r.nxt = CH_W'(i);
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (!mask[i] && CH_W'(i) > cur) begin
        r.nxt = CH_W'(i);
        r.last = 1'b0;
      end
    return r;
  endfunction
endpackage

// File: rtl/scan_select_seq_timer.sv
// dwell_timer: loadable down-counter that holds at zero, shared by dwell and gap timing
module dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         en,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= rst ? '0 : load ? val : (en && cnt != '0) ? cnt - 1'b1 : cnt;
  assign zero = cnt == '0;
endmodule

// File: rtl/scan_select_seq.sv
// scan_select_seq: 3-to-8 decoder select/enable sequencer with dwell, break-before-make gap, loop mode and optional SCAN_SKIP_EN skip mask
module scan_select_seq
  import scan_seq_pkg::*;
#(
  parameter int DWELL_W = 8,
  parameter int GAP_CYC = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic               sel_a,
  output logic               sel_b,
  output logic               sel_c,
  output logic               sel_en,
  output logic               busy,
  output logic               done,
  output logic               wrap
`ifdef SCAN_SKIP_EN
  ,
  input  logic [NUM_CH-1:0]  skip_mask
`endif
);
  localparam logic [DWELL_W-1:0] GAP_VAL = DWELL_W'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
  state_t state, state_n;
  logic [CH_W-1:0] ch, ch_n;
  logic [DWELL_W-1:0] d_q, d_n, d_in, tval;
  logic [NUM_CH-1:0] mask_q, mask_n, mask_in;
  logic loop_q, loop_n, en_n, done_n, wrap_n, tload, zero;
  ch_step_t step, first;
`ifdef SCAN_SKIP_EN
  assign mask_in = skip_mask;
`else
  assign mask_in = '0;
`endif
  assign d_in = dwell == '0 ? DWELL_W'(1) : dwell;
  assign {sel_a, sel_b, sel_c} = ch;
  dwell_timer #(.W(DWELL_W)) u_timer (
    .clk (clk),
    .rst (rst),
    .load(tload),
    .val (tval),
    .en  (state != IDLE),
    .zero(zero)
  );
  always_comb begin
    step = next_ch(ch, mask_q);
    first = next_ch(CH_W'(NUM_CH - 1), mask_in);
    state_n = state;
    ch_n = ch;
    en_n = sel_en;
    done_n = 1'b0;
    wrap_n = 1'b0;
    d_n = d_q;
    loop_n = loop_q;
    mask_n = mask_q;
    tload = 1'b0;
    tval = d_q - 1'b1;
    case (state)
      IDLE:
        if (start && !stop) begin
          d_n = d_in;
          loop_n = loop_mode;
          mask_n = mask_in;
          done_n = &mask_in;
          if (!(&mask_in)) begin
            state_n = DWELL;
            ch_n = first.nxt;
            en_n = 1'b1;
            tload = 1'b1;
            tval = d_in - 1'b1;
          end
        end
      DWELL:
        if (zero) begin
          if (step.last && !loop_q) begin
            state_n = IDLE;
            en_n = 1'b0;
            done_n = 1'b1;
          end else if (GAP_CYC > 0) begin
            state_n = GAP;
            en_n = 1'b0;
            tload = 1'b1;
            tval = GAP_VAL;
          end else begin
            ch_n = step.nxt;
            tload = 1'b1;
            wrap_n = step.last;
          end
        end
      GAP:
        if (zero) begin
          state_n = DWELL;
          ch_n = step.nxt;
          en_n = 1'b1;
          tload = 1'b1;
          wrap_n = step.last;
        end
      default: state_n = IDLE;
    endcase
    if (stop) begin
      state_n = IDLE;
      en_n = 1'b0;
      done_n = 1'b0;
      wrap_n = 1'b0;
      tload = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ch <= '0;
      sel_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      wrap <= 1'b0;
      d_q <= '0;
      loop_q <= 1'b0;
      mask_q <= '0;
    end else begin
      state <= state_n;
      ch <= ch_n;
      sel_en <= en_n;
      busy <= state_n != IDLE;
      done <= done_n;
      wrap <= wrap_n;
      d_q <= d_n;
      loop_q <= loop_n;
      mask_q <= mask_n;
    end
endmodule

// File: tb/tb_scan_select_seq.sv
// tb_scan_select_seq: directed self-checking bench for scan_select_seq
module tb_scan_select_seq;
  localparam int GAP = 1;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, loop_mode = 1'b0;
  logic [7:0] dwell = '0;
  logic sel_a, sel_b, sel_c, sel_en, busy, done, wrap;
  logic [6:0] obs, exp_v;
  int tests = 0, fails = 0;
`ifdef SCAN_SKIP_EN
  logic [7:0] skip_mask = '0;
`endif
  always #5 clk = ~clk;
  scan_select_seq #(.DWELL_W(8), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_mode(loop_mode), .dwell(dwell),
    .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c), .sel_en(sel_en), .busy(busy), .done(done), .wrap(wrap)
`ifdef SCAN_SKIP_EN
    , .skip_mask(skip_mask)
`endif
  );
  assign obs = {sel_a, sel_b, sel_c, sel_en, busy, done, wrap};
  function automatic logic [6:0] vec(input int ch, input bit en, input bit bsy, input bit dn, input bit wr);
    return {3'(ch), en, bsy, dn, wr};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    tests++;
    if (obs !== 7'b0) begin fails++; $display("FAIL reset_init obs=%b exp=%b", obs, 7'b0); end
    rst = 1'b0;
    dwell = 8'd3;
    loop_mode = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tests++;
    if (obs !== vec(0, 1, 1, 0, 0)) begin fails++; $display("FAIL reset_prestart obs=%b exp=%b", obs, vec(0, 1, 1, 0, 0)); end
    repeat (5) tick;
    rst = 1'b1;
    tick;
    tests++;
    if (obs !== 7'b0) begin fails++; $display("FAIL reset_mid1 obs=%b exp=%b", obs, 7'b0); end
    tick;
    tests++;
    if (obs !== 7'b0) begin fails++; $display("FAIL reset_mid2 obs=%b exp=%b", obs, 7'b0); end
    rst = 1'b0;
    loop_mode = 1'b0;
    tick;
    tests++;
    if (obs !== 7'b0) begin fails++; $display("FAIL reset_release obs=%b exp=%b", obs, 7'b0); end
  endtask
  task automatic run_oneshot(input string name, input int d_in, input int retrig_k);
    int d, p, last;
    d = d_in == 0 ? 1 : d_in;
    p = d + GAP;
    last = 8 * d + 7 * GAP;
    dwell = 8'(d_in);
    loop_mode = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k <= last + 1; k++) begin
      exp_v = k < last ? vec(k / p, (k % p) < d, 1, 0, 0) : k == last ? vec(7, 0, 0, 1, 0) : vec(7, 0, 0, 0, 0);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL %s k=%0d obs=%b exp=%b", name, k, obs, exp_v); end
      if (k == retrig_k) begin
        start = 1'b1;
        dwell = 8'd5;
        loop_mode = 1'b1;
      end else begin
        start = 1'b0;
        dwell = 8'(d_in);
        loop_mode = 1'b0;
      end
      tick;
    end
  endtask
  task automatic test_one_shot;
    run_oneshot("one_shot", 3, -1);
  endtask
  task automatic test_dwell_zero;
    run_oneshot("dwell_zero", 0, -1);
  endtask
  task automatic test_retrigger;
    run_oneshot("retrigger", 2, 5);
  endtask
  task automatic test_loop;
    dwell = 8'd1;
    loop_mode = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    loop_mode = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      exp_v = vec((k / 2) % 8, k % 2 == 0, 1, 0, k > 0 && k % 16 == 0);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL loop k=%0d obs=%b exp=%b", k, obs, exp_v); end
      if (k < 40) tick;
    end
    stop = 1'b1;
    tick;
    stop = 1'b0;
    tests++;
    if (obs !== vec(4, 0, 0, 0, 0)) begin fails++; $display("FAIL loop_stop obs=%b exp=%b", obs, vec(4, 0, 0, 0, 0)); end
    for (int k = 0; k < 3; k++) begin
      tick;
      tests++;
      if (obs !== vec(4, 0, 0, 0, 0)) begin fails++; $display("FAIL loop_after_stop k=%0d obs=%b exp=%b", k, obs, vec(4, 0, 0, 0, 0)); end
    end
  endtask
  task automatic test_start_stop;
    dwell = 8'd2;
    start = 1'b1;
    stop = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick;
      tests++;
      if (obs !== vec(4, 0, 0, 0, 0)) begin fails++; $display("FAIL start_stop k=%0d obs=%b exp=%b", k, obs, vec(4, 0, 0, 0, 0)); end
    end
    start = 1'b0;
    stop = 1'b0;
    tick;
    tests++;
    if (obs !== vec(4, 0, 0, 0, 0)) begin fails++; $display("FAIL start_stop_after obs=%b exp=%b", obs, vec(4, 0, 0, 0, 0)); end
  endtask
`ifdef SCAN_SKIP_EN
  task automatic test_skip;
    logic [2:0] chs [4];
    chs = '{3'd0, 3'd2, 3'd4, 3'd6};
    skip_mask = 8'hAA;
    dwell = 8'd1;
    start = 1'b1;
    tick;
    start = 1'b0;
    skip_mask = 8'h00;
    for (int k = 0; k <= 7; k++) begin
      exp_v = k == 7 ? vec(6, 0, 0, 1, 0) : vec(chs[k / 2], k % 2 == 0, 1, 0, 0);
      tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL skip_aa k=%0d obs=%b exp=%b", k, obs, exp_v); end
      tick;
    end
    skip_mask = 8'hFF;
    start = 1'b1;
    tick;
    start = 1'b0;
    tests++;
    if (obs !== vec(6, 0, 0, 1, 0)) begin fails++; $display("FAIL skip_ff_done obs=%b exp=%b", obs, vec(6, 0, 0, 1, 0)); end
    tick;
    tests++;
    if (obs !== vec(6, 0, 0, 0, 0)) begin fails++; $display("FAIL skip_ff_after obs=%b exp=%b", obs, vec(6, 0, 0, 0, 0)); end
    skip_mask = 8'h00;
  endtask
`endif
  initial begin
    test_reset;
    test_one_shot;
    test_dwell_zero;
    test_retrigger;
    test_loop;
    test_start_stop;
`ifdef SCAN_SKIP_EN
    test_skip;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
